// File: rtl/app_test_core.sv
// Production-test core for the app board: pin rotation on RTS, RGB LED cycling,
// touch counting and a periodic 2-byte UART report on tx.
module app_test_core #(
  parameter int LED_DIV_BITS = 25,
  parameter int TICK_BITS    = 25,
  parameter int BIT_CYCLES   = 2500
) (
  input  logic clk,
  input  logic rst,
  input  logic rts,
  input  logic touch_event,
  output logic tx,
  output logic cts,
  output logic app_gpio1,
  output logic app_gpio2,
  output logic app_gpio3,
  output logic app_gpio4,
  output logic rgb0_pwm,
  output logic rgb1_pwm,
  output logic rgb2_pwm,
  output logic rgbleden
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(BIT_CYCLES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [1:0]              rts_sync, touch_sync;
  logic                    rts_prev, touch_prev;
  logic                    rts_rise, touch_rise;
  logic [4:0]              pintest;
  logic [LED_DIV_BITS-1:0] led_div;
  logic [2:0]              led_state;
  logic [7:0]              touch_count;
  logic [TICK_BITS-1:0]    ticks;
  logic                    tick_hit;
  state_t                  state;
  logic [19:0]             shift;
  logic [4:0]              bits_left;
  logic [CNT_W-1:0]        bit_cnt;
  logic [7:0]              report_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rts_sync   <= '0;
      touch_sync <= '0;
      rts_prev   <= 1'b0;
      touch_prev <= 1'b0;
    end else begin
      rts_sync   <= {rts_sync[0], rts};
      touch_sync <= {touch_sync[0], touch_event};
      rts_prev   <= rts_sync[1];
      touch_prev <= touch_sync[1];
    end
  end

  assign rts_rise   = rts_sync[1] & ~rts_prev;
  assign touch_rise = touch_sync[1] & ~touch_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pintest <= 5'h01;
    end else if (rts_rise) begin
      case (pintest)
        5'h01:   pintest <= 5'h02;
        5'h02:   pintest <= 5'h04;
        5'h04:   pintest <= 5'h08;
        5'h08:   pintest <= 5'h10;
        default: pintest <= 5'h01;
      endcase
    end
  end

  assign {cts, app_gpio1, app_gpio2, app_gpio3, app_gpio4} = pintest;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_div   <= '0;
      led_state <= 3'b100;
    end else begin
      led_div <= led_div + 1'b1;
      case (led_div[LED_DIV_BITS-1 -: 2])
        2'd0:    led_state <= 3'b100;
        2'd1:    led_state <= 3'b010;
        2'd2:    led_state <= 3'b001;
        default: led_state <= 3'b111;
      endcase
    end
  end

  assign rgb0_pwm = led_state[2];
  assign rgb1_pwm = led_state[1];
  assign rgb2_pwm = led_state[0];
  // Raw pad, deliberately unsynchronised: a touch blanks the LEDs at once.
  assign rgbleden = ~touch_event;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      touch_count <= '0;
      ticks       <= '0;
    end else begin
      ticks <= ticks + 1'b1;
      if (touch_rise) touch_count <= touch_count + 8'd1;
    end
  end

  assign tick_hit = (ticks == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      shift        <= '1;
      bits_left    <= '0;
      bit_cnt      <= '0;
      report_count <= '0;
      tx           <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (tick_hit) begin
            shift        <= {1'b1, touch_count, 1'b0, 1'b1, report_count, 1'b0};
            bits_left    <= 5'd20;
            bit_cnt      <= BIT_RELOAD;
            report_count <= report_count + 8'd1;
            // Start bit goes out on the load edge so every bit lasts BIT_CYCLES.
            tx           <= 1'b0;
            state        <= SEND;
          end
        end
        SEND: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end else begin
            bit_cnt   <= BIT_RELOAD;
            bits_left <= bits_left - 5'd1;
            if (bits_left == 5'd1) begin
              tx    <= 1'b1;
              state <= IDLE;
            end else begin
              shift <= {1'b1, shift[19:1]};
              tx    <= shift[1];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_app_test_core.sv
// Randomised self-checking bench for app_test_core: every output is compared each
// cycle against a cycle-count/event-list model, plus UART frame decoding.
module tb_app_test_core;

  localparam int LDB    = 4;
  localparam int TB     = 8;
  localparam int BC     = 4;
  localparam int PERIOD = 1 << TB;
  localparam int LEDP   = 1 << LDB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rts = 1'b0;
  logic touch_event = 1'b0;
  logic tx, cts, app_gpio1, app_gpio2, app_gpio3, app_gpio4;
  logic rgb0_pwm, rgb1_pwm, rgb2_pwm, rgbleden;

  int vectors = 0;
  int errors  = 0;
  int n = 0;
  int rts_eff[$];
  int touch_eff[$];

  app_test_core #(.LED_DIV_BITS(LDB), .TICK_BITS(TB), .BIT_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .rts(rts), .touch_event(touch_event), .tx(tx),
    .cts(cts), .app_gpio1(app_gpio1), .app_gpio2(app_gpio2),
    .app_gpio3(app_gpio3), .app_gpio4(app_gpio4),
    .rgb0_pwm(rgb0_pwm), .rgb1_pwm(rgb1_pwm), .rgb2_pwm(rgb2_pwm),
    .rgbleden(rgbleden)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; the model is expressed in terms of this.
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  function automatic int count_rts(input int lim);
    int c = 0;
    foreach (rts_eff[i]) if (rts_eff[i] <= lim) c++;
    return c;
  endfunction

  function automatic int count_touch(input int lim);
    int c = 0;
    foreach (touch_eff[i]) if (touch_eff[i] <= lim) c++;
    return c;
  endfunction

  function automatic logic [4:0] pins_exp(input int e);
    return 5'b00001 << (count_rts(e) % 5);
  endfunction

  function automatic logic [2:0] pwm_exp(input int e);
    int m;
    m = (e == 0) ? 0 : e - 1;
    case ((m % LEDP) / (LEDP / 4))
      0:       return 3'b100;
      1:       return 3'b010;
      2:       return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic tx_exp(input int e);
    int L, off;
    logic [7:0] rc, tc;
    logic [19:0] frame;
    if (e < PERIOD) return 1'b1;
    L   = (e / PERIOD) * PERIOD;
    off = e - L;
    if (off >= 20 * BC) return 1'b1;
    rc    = 8'((e / PERIOD) - 1);
    tc    = 8'(count_touch(L - 1));
    frame = {1'b1, tc, 1'b0, 1'b1, rc, 1'b0};
    return frame[off / BC];
  endfunction

  always @(negedge clk) begin
    logic leden_exp;
    leden_exp = ~touch_event;
    check("tx", {31'b0, tx}, {31'b0, tx_exp(n)});
    check("pins", {27'b0, cts, app_gpio1, app_gpio2, app_gpio3, app_gpio4}, {27'b0, pins_exp(n)});
    check("pwm", {29'b0, rgb0_pwm, rgb1_pwm, rgb2_pwm}, {29'b0, pwm_exp(n)});
    check("leden", {31'b0, rgbleden}, {31'b0, leden_exp});
  end

  task automatic pulse_rts(input int hi, input int lo);
    @(posedge clk); #1;
    rts = 1'b1;
    rts_eff.push_back(n + 3);
    repeat (hi) @(posedge clk);
    #1 rts = 1'b0;
    repeat (lo) @(posedge clk);
  endtask

  task automatic pulse_touch(input int hi, input int lo);
    @(posedge clk); #1;
    touch_event = 1'b1;
    touch_eff.push_back(n + 3);
    repeat (hi) @(posedge clk);
    #1 touch_event = 1'b0;
    repeat (lo) @(posedge clk);
  endtask

  task automatic decode_frame(output logic [7:0] b0, output logic [7:0] b1);
    logic [19:0] bits;
    int waited;
    b0 = '0;
    b1 = '0;
    waited = 0;
    while ((n % PERIOD) < 90 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    waited = 0;
    @(negedge clk);
    while (tx !== 1'b0 && waited < 600) begin
      @(negedge clk);
      waited++;
    end
    if (tx !== 1'b0) begin
      check("frame_start_timeout", {31'b0, tx}, 32'd0);
      return;
    end
    repeat (BC / 2) @(negedge clk);
    bits[0] = tx;
    for (int i = 1; i < 20; i++) begin
      repeat (BC) @(negedge clk);
      bits[i] = tx;
    end
    check("start0", {31'b0, bits[0]}, 32'd0);
    check("stop0", {31'b0, bits[9]}, 32'd1);
    check("start1", {31'b0, bits[10]}, 32'd0);
    check("stop1", {31'b0, bits[19]}, 32'd1);
    b0 = bits[8:1];
    b1 = bits[18:11];
  endtask

  initial begin
    logic [7:0] b0, b1;
    int target, waited, rc_exp;

    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_pins", {27'b0, cts, app_gpio1, app_gpio2, app_gpio3, app_gpio4}, 32'h01);
    check("rst_pwm", {29'b0, rgb0_pwm, rgb1_pwm, rgb2_pwm}, 32'h4);
    #1 touch_event = 1'b1;
    #1 check("rst_leden_touch", {31'b0, rgbleden}, 32'd0);
    touch_event = 1'b0;
    #1 check("rst_leden_idle", {31'b0, rgbleden}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    repeat (40) @(posedge clk);

    for (int i = 0; i < 6; i++) pulse_rts(5, $urandom_range(3, 6));
    repeat (4) @(posedge clk);
    #1 check("pins_after_6", {27'b0, cts, app_gpio1, app_gpio2, app_gpio3, app_gpio4}, 32'h02);

    for (int i = 0; i < 3; i++) pulse_touch($urandom_range(2, 3), $urandom_range(2, 4));
    decode_frame(b0, b1);
    check("frame1_rc", {24'b0, b0}, 32'h00);
    check("frame1_tc", {24'b0, b1}, 32'h03);
    decode_frame(b0, b1);
    check("frame2_rc", {24'b0, b0}, 32'h01);
    check("frame2_tc", {24'b0, b1}, 32'h03);

    target = (n / PERIOD + 1) * PERIOD + 7 * BC + 2;
    waited = 0;
    while (n < target && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check("bit7_reached", {31'b0, (n >= target)}, 32'd1);
    check("bit7_tx", {31'b0, tx}, {31'b0, tx_exp(n)});
    #1 rst = 1'b1;
    rts_eff.delete();
    touch_eff.delete();
    #1 check("midframe_rst_tx", {31'b0, tx}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    decode_frame(b0, b1);
    check("post_rst_rc", {24'b0, b0}, 32'h00);
    check("post_rst_tc", {24'b0, b1}, 32'h00);

    for (int i = 0; i < 256; i++) pulse_touch($urandom_range(2, 3), $urandom_range(2, 3));
    repeat (5) @(posedge clk);
    decode_frame(b0, b1);
    rc_exp = (n / PERIOD) - 1;
    check("wrap_rc", {24'b0, b0}, {24'b0, 8'(rc_exp)});
    check("wrap_tc", {24'b0, b1}, 32'h00);

    repeat (10) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
